// File: rtl/gate_truth_checker.sv
// Sweeps every input vector through a combinational gate under test, holds each
// vector for SETTLE cycles, samples the gate output and checks it against TRUTH.
module gate_truth_checker #(
    parameter int                    N_IN   = 2,
    parameter logic [2**N_IN-1:0]    TRUTH  = 4'b1000,
    parameter int                    SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   dut_in,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     fail_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              res_valid,
    output logic [N_IN-1:0]   res_vec,
    output logic              res_ok,
    output logic [1:0]        state_dbg
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            sample;
    logic            last_vec;
    logic            mismatch;

    // dut_in doubles as the vector counter; sampling happens once the hold count reaches SETTLE.
    assign sample    = (state_q == RUN) && (cnt_q == SETTLE_C);
    assign last_vec  = (dut_in == {N_IN{1'b1}});
    assign mismatch  = (dut_out != TRUTH[dut_in]);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) state_d = RUN;
                RUN:        if (sample && last_vec) state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            res_valid      <= 1'b0;
            res_vec        <= '0;
            res_ok         <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (abort) begin
                // Results of the interrupted sweep stay visible for inspection.
                cnt_q  <= '0;
                dut_in <= '0;
                busy   <= 1'b0;
                done   <= 1'b0;
                pass   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            fail_count     <= '0;
                            first_fail_vec <= '0;
                            pass           <= 1'b0;
                            done           <= 1'b0;
                            dut_in         <= '0;
                            cnt_q          <= '0;
                            busy           <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (sample) begin
                            res_valid <= 1'b1;
                            res_vec   <= dut_in;
                            res_ok    <= !mismatch;
                            cnt_q     <= '0;
                            if (mismatch) begin
                                fail_count <= fail_count + (N_IN+1)'(1);
                                if (fail_count == '0) first_fail_vec <= dut_in;
                            end
                            if (last_vec) begin
                                dut_in <= '0;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                pass   <= (fail_count == '0) && !mismatch;
                            end else begin
                                dut_in <= dut_in + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (default AND checker and an XOR
// checker with SETTLE=1) driving table-based gate models.
module tb_gate_truth_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [3:0] gate_tt0 = 4'b1000, gate_tt1 = 4'b0110;

    logic [1:0] dut_in0, dut_in1, ffv0, ffv1, rvec0, rvec1, st0, st1;
    logic [2:0] fc0, fc1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic       rv0, rv1, rok0, rok1, dout0, dout1;

    int checks = 0;
    int failures = 0;

    // Gate models: output is a lookup of the current input vector.
    assign dout0 = gate_tt0[dut_in0];
    assign dout1 = gate_tt1[dut_in1];

    always #5 clk = ~clk;

    gate_truth_checker u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .dut_in(dut_in0), .dut_out(dout0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_count(fc0), .first_fail_vec(ffv0), .res_valid(rv0), .res_vec(rvec0),
        .res_ok(rok0), .state_dbg(st0)
    );

    gate_truth_checker #(.N_IN(2), .TRUTH(4'b0110), .SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .dut_in(dut_in1), .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .first_fail_vec(ffv1), .res_valid(rv1), .res_vec(rvec1),
        .res_ok(rok1), .state_dbg(st1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input int sel, input string tag, input logic [1:0] din,
                               input logic b, input logic d, input logic p);
        if (sel == 0) begin
            chk({tag, "_dut_in"}, 32'(dut_in0), 32'(din));
            chk({tag, "_busy"}, 32'(busy0), 32'(b));
            chk({tag, "_done"}, 32'(done0), 32'(d));
            chk({tag, "_pass"}, 32'(pass0), 32'(p));
        end else begin
            chk({tag, "_dut_in"}, 32'(dut_in1), 32'(din));
            chk({tag, "_busy"}, 32'(busy1), 32'(b));
            chk({tag, "_done"}, 32'(done1), 32'(d));
            chk({tag, "_pass"}, 32'(pass1), 32'(p));
        end
    endtask

    // Full sweep on instance sel with the given gate; expectations come from a
    // whole-sweep model: per-vector compare, mismatch popcount, lowest failing index.
    task automatic run_sweep(input int sel, input logic [3:0] gate, input logic [3:0] truth,
                             input int s, input bit noise);
        int total, nfail, first, k;
        logic rv, rok, b, d, p;
        logic [1:0] din, rvec, ffv;
        logic [2:0] fc;
        total = 4 * (s + 1);
        nfail = 0;
        first = -1;
        for (int i = 0; i < 4; i++) begin
            if (gate[i] != truth[i]) begin
                nfail++;
                if (first < 0) first = i;
            end
        end
        if (first < 0) first = 0;
        if (sel == 0) begin gate_tt0 = gate; start0 = 1'b1; end
        else          begin gate_tt1 = gate; start1 = 1'b1; end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        for (int e = 1; e <= total; e++) begin
            @(posedge clk); #1;
            if (sel == 0) begin
                rv = rv0; rok = rok0; rvec = rvec0; din = dut_in0; b = busy0; d = done0;
                p = pass0; fc = fc0; ffv = ffv0;
            end else begin
                rv = rv1; rok = rok1; rvec = rvec1; din = dut_in1; b = busy1; d = done1;
                p = pass1; fc = fc1; ffv = ffv1;
            end
            chk("res_valid", 32'(rv), 32'((e % (s + 1)) == 0));
            if ((e % (s + 1)) == 0) begin
                k = e / (s + 1) - 1;
                chk("res_vec", 32'(rvec), 32'(k));
                chk("res_ok", 32'(rok), 32'(gate[k] == truth[k]));
            end
            if (e == 1) begin
                chk("clr_fail_count", 32'(fc), 32'd0);
                chk("clr_pass", 32'(p), 32'd0);
            end
            if (e < total) begin
                chk("run_dut_in", 32'(din), 32'(e / (s + 1)));
                chk("run_busy", 32'(b), 32'd1);
                chk("run_done", 32'(d), 32'd0);
                if (noise) begin
                    if (sel == 0) start0 = 1'($urandom_range(0, 1));
                    else          start1 = 1'($urandom_range(0, 1));
                end
            end else begin
                start0 = 1'b0; start1 = 1'b0;
                chk_outputs(sel, "end", 2'd0, 1'b0, 1'b1, 1'(nfail == 0));
                chk("end_fail_count", 32'(fc), 32'(nfail));
                chk("end_first_fail_vec", 32'(ffv), 32'(first));
            end
        end
        // Results hold in DONE and no further strobes appear.
        repeat (2) @(posedge clk);
        #1;
        if (sel == 0) begin
            chk("hold_done", 32'(done0), 32'd1);
            chk("hold_res_valid", 32'(rv0), 32'd0);
        end else begin
            chk("hold_done", 32'(done1), 32'd1);
            chk("hold_res_valid", 32'(rv1), 32'd0);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk_outputs(0, "rst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_fail_count", 32'(fc0), 32'd0);
        chk("rst_res_valid", 32'(rv0), 32'd0);
        chk("rst_state", 32'(st0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // AND, stuck-at-0, NAND on the default checker
        run_sweep(0, 4'b1000, 4'b1000, 4, 1'b0);
        run_sweep(0, 4'b0000, 4'b1000, 4, 1'b0);
        run_sweep(0, 4'b0111, 4'b1000, 4, 1'b0);

        // Start during RUN ignored; abort clears control outputs, keeps results
        gate_tt0 = 4'b0111;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            if (e == 2) start0 = 1'b1;
            if (e == 3) begin
                start0 = 1'b0;
                chk("ign_busy", 32'(busy0), 32'd1);
                chk("ign_dut_in", 32'(dut_in0), 32'd0);
            end
            if (e == 7) abort0 = 1'b1;
        end
        @(posedge clk); #1;
        abort0 = 1'b0;
        chk_outputs(0, "abort", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("abort_res_valid", 32'(rv0), 32'd0);
        chk("abort_state", 32'(st0), 32'd0);
        chk("abort_fail_count", 32'(fc0), 32'd1);
        chk("abort_first_fail_vec", 32'(ffv0), 32'd0);

        // Abort together with start: nothing starts
        abort0 = 1'b1; start0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0; start0 = 1'b0;
        @(posedge clk); #1;
        chk("abort_start_busy", 32'(busy0), 32'd0);
        chk("abort_start_state", 32'(st0), 32'd0);

        run_sweep(0, 4'b1000, 4'b1000, 4, 1'b0);

        // Asynchronous reset mid-run
        gate_tt0 = 4'b1000;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_outputs(0, "arst", 2'd0, 1'b0, 1'b0, 1'b0);
        chk("arst_fail_count", 32'(fc0), 32'd0);
        chk("arst_res_valid", 32'(rv0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_dut_in", 32'(dut_in0), 32'd0);
        chk("post_rst_busy", 32'(busy0), 32'd0);

        // XOR checker, SETTLE=1, then a restart from DONE with a broken gate
        run_sweep(1, 4'b0110, 4'b0110, 1, 1'b0);
        run_sweep(1, 4'b1111, 4'b0110, 1, 1'b0);

        // Random gate tables with start noise during the run
        for (int r = 0; r < 8; r++) begin
            run_sweep(0, 4'($urandom_range(0, 15)), 4'b1000, 4, 1'b1);
            run_sweep(1, 4'($urandom_range(0, 15)), 4'b0110, 1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
